synth_partial_scheduler: RTL and testbench

- Sequences the shared Synth sine datapath across NUM_PARTIALS configurable partials to build one additive-synthesis output sample per sample index x.
- Holds a double-buffered partial table (enable, magnitude, frequency bin, phase).
- For each sample it issues every partial to the datapath, accumulates the returned products and emits one saturated sample under a valid/ready handshake.
- Sits between the host configuration path and the audio output stream.

---
 rtl/synth_pkg.sv | 16 +
 rtl/synth_partial_table.sv | 33 +++
 rtl/synth_partial_scheduler.sv | 141 ++++++++++++++
 tb/tb_synth_partial_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types for the additive-synthesis partial scheduler.
package synth_pkg;
  localparam int SAMPLE_COUNT = 2048;
  localparam int FREQ_W       = 11;
  localparam int X_W          = 11;
  localparam int PART_W       = 16;

  typedef struct packed {
    logic                     enable;
    logic signed [PART_W-1:0] magnitude;
    logic [FREQ_W-1:0]        frequency;
    logic signed [PART_W-1:0] phase;
  } partial_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} sched_state_t;
endpackage

// File: rtl/synth_partial_table.sv
// Double-buffered partial table: host writes land in shadow, commit copies
// the whole shadow bank into the active bank read by the issue counter.
module synth_partial_table
  import synth_pkg::*;
#(
  parameter int NUM_PARTIALS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_PARTIALS)-1:0] wr_idx,
  input  partial_t                        wr_data,
  input  logic                            clr,
  input  logic                            commit,
  input  logic [$clog2(NUM_PARTIALS)-1:0] rd_idx,
  output partial_t                        rd_data
);
  partial_t [NUM_PARTIALS-1:0] shadow, active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (clr)        shadow         <= '0;
      else if (wr_en) shadow[wr_idx] <= wr_data;
      // commit sees the pre-write shadow, so a same-cycle write lands next sample
      if (commit)     active         <= shadow;
    end
  end

  assign rd_data = active[rd_idx];
endmodule

// File: rtl/synth_partial_scheduler.sv
// Issues every partial to the shared sine datapath once per sample, sums the
// returned products and emits one saturated sample per x under valid/ready.
module synth_partial_scheduler
  import synth_pkg::*;
#(
  parameter int SIZE         = PART_W,
  parameter int NUM_PARTIALS = 8,
  parameter int SYN_LAT      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            cfg_wr_en,
  input  logic [$clog2(NUM_PARTIALS)-1:0] cfg_idx,
  input  logic                            cfg_enable,
  input  logic [SIZE-1:0]                 cfg_magnitude,
  input  logic [FREQ_W-1:0]               cfg_frequency,
  input  logic [SIZE-1:0]                 cfg_phase,
  input  logic                            clr,
  output logic                            syn_valid,
  output logic [SIZE-1:0]                 syn_magnitude,
  output logic [FREQ_W-1:0]               syn_frequency,
  output logic [SIZE-1:0]                 syn_phase,
  output logic [X_W-1:0]                  syn_x,
  input  logic [SIZE-1:0]                 syn_result,
  output logic [SIZE-1:0]                 out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);
  localparam int IDX_W = $clog2(NUM_PARTIALS);
  localparam int ACC_W = SIZE + IDX_W;
  localparam int DC_W  = $clog2(SYN_LAT + 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(IDX_W+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(IDX_W+1){1'b1}}, {(SIZE-1){1'b0}}};

  sched_state_t             state;
  logic [IDX_W-1:0]         cnt;
  logic [DC_W-1:0]          dcnt;
  logic [X_W-1:0]           x;
  logic                     pend;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [SIZE-1:0]          sat_val;
  logic [SYN_LAT:1]         vld_pipe;
  logic                     tag_in, accept, commit;
  partial_t                 cfg_entry, rd;

  assign cfg_entry = '{cfg_enable, cfg_magnitude, cfg_frequency, cfg_phase};
  assign accept    = (state == EMIT) && out_ready;
  assign commit    = ((state == IDLE) && start) || (accept && !(pend || stop));

  synth_partial_table #(.NUM_PARTIALS(NUM_PARTIALS)) u_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cfg_wr_en),
    .wr_idx (cfg_idx),
    .wr_data(cfg_entry),
    .clr    (clr),
    .commit (commit),
    .rd_idx (cnt),
    .rd_data(rd)
  );

  assign syn_magnitude = syn_valid ? rd.magnitude : '0;
  assign syn_frequency = syn_valid ? rd.frequency : '0;
  assign syn_phase     = syn_valid ? rd.phase     : '0;
  assign syn_x         = x;
  assign busy          = (state != IDLE);

  // Disabled partials still issue; their enable rides along so the result is dropped.
  assign tag_in   = syn_valid & rd.enable;
  assign acc_next = acc + (vld_pipe[SYN_LAT] ? {{IDX_W{syn_result[SIZE-1]}}, syn_result}
                                             : {ACC_W{1'b0}});

  always_comb begin
    sat_val = acc_next[SIZE-1:0];
    if (acc_next > SAT_HI)      sat_val = {1'b0, {(SIZE-1){1'b1}}};
    else if (acc_next < SAT_LO) sat_val = {1'b1, {(SIZE-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      x         <= '0;
      pend      <= 1'b0;
      acc       <= '0;
      vld_pipe  <= '0;
      syn_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      acc         <= acc_next;
      vld_pipe[1] <= tag_in;
      for (int i = 2; i <= SYN_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (stop && state != IDLE) pend <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          cnt       <= '0;
          x         <= '0;
          acc       <= '0;
          pend      <= stop;
          syn_valid <= 1'b1;
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(NUM_PARTIALS - 1)) begin
            state     <= DRAIN;
            dcnt      <= '0;
            syn_valid <= 1'b0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DC_W'(SYN_LAT - 1)) begin
            state     <= EMIT;
            out_valid <= 1'b1;
            out_data  <= sat_val;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          x         <= (x == X_W'(SAMPLE_COUNT - 1)) ? '0 : x + 1'b1;
          if (pend || stop) begin
            state <= IDLE;
            pend  <= 1'b0;
          end else begin
            state     <= ISSUE;
            cnt       <= '0;
            acc       <= '0;
            syn_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synth_partial_scheduler.sv
// Directed bench for synth_partial_scheduler with a 4-partial, 2-cycle datapath model.
module tb_synth_partial_scheduler;
  localparam int SIZE = 16;
  localparam int N    = 4;
  localparam int LAT  = 2;

  logic             clk = 1'b0;
  logic             rst, start, stop, cfg_wr_en, cfg_enable, clr, out_ready;
  logic [1:0]       cfg_idx;
  logic [SIZE-1:0]  cfg_magnitude, cfg_phase, syn_magnitude, syn_phase, syn_result, out_data;
  logic [10:0]      cfg_frequency, syn_frequency, syn_x;
  logic             syn_valid, out_valid, busy;
  logic [SIZE-1:0]  d1, d2;

  int checks   = 0;
  int failures = 0;

  synth_partial_scheduler #(.SIZE(SIZE), .NUM_PARTIALS(N), .SYN_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable),
    .cfg_magnitude(cfg_magnitude), .cfg_frequency(cfg_frequency), .cfg_phase(cfg_phase),
    .clr(clr), .syn_valid(syn_valid), .syn_magnitude(syn_magnitude),
    .syn_frequency(syn_frequency), .syn_phase(syn_phase), .syn_x(syn_x),
    .syn_result(syn_result), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // datapath model: result = issued magnitude, LAT cycles later
  always_ff @(posedge clk) begin
    d1 <= syn_magnitude;
    d2 <= d1;
  end
  assign syn_result = d2;

  function automatic logic [31:0] w16(input int v);
    return {16'h0, v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic en, input int mag);
    cfg_wr_en = 1'b1; cfg_idx = 2'(idx); cfg_enable = en;
    cfg_magnitude = 16'(mag); cfg_frequency = 11'(idx + 3); cfg_phase = 16'(idx * 7);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic load4(input int m0, input int m1, input int m2, input int m3);
    wr(0, 1'b1, m0); wr(1, 1'b1, m1); wr(2, 1'b1, m2); wr(3, 1'b1, m3);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  // start+stop together: exactly one sample, then idle
  task automatic one_sample(input string tag, input int exp);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    wait_valid(tag);
    chk({tag, "_data"}, w16(int'(out_data)), w16(exp));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int mags[4];
    int n, acc_cnt;
    logic seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_wr_en = 1'b0; cfg_idx = '0; cfg_enable = 1'b0;
    cfg_magnitude = '0; cfg_frequency = '0; cfg_phase = '0; clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_syn_valid", 32'(syn_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_syn_x", 32'(syn_x), 0);
    rst = 1'b0;
    tick();

    // reset in the middle of ISSUE
    wr(0, 1'b1, 100);
    start = 1'b1; tick(); start = 1'b0;
    chk("pre_rst_syn_valid", 32'(syn_valid), 1);
    tick();
    rst = 1'b1; #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_syn_valid", 32'(syn_valid), 0);
    tick(); rst = 1'b0; tick();
    one_sample("after_rst_zero", 0);

    // basic sum with cycle-accurate latency
    mags = '{100, 200, 300, -50};
    load4(100, 200, 300, -50);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("basic_issue_valid", 32'(syn_valid), 1);
      chk("basic_issue_mag", w16(int'(syn_magnitude)), w16(mags[i]));
      chk("basic_issue_x", 32'(syn_x), 0);
      tick();
    end
    chk("basic_c5_syn_valid", 32'(syn_valid), 0);
    tick();
    chk("basic_c6_out_valid", 32'(out_valid), 0);
    tick();
    chk("basic_c7_out_valid", 32'(out_valid), 1);
    chk("basic_sum", w16(int'(out_data)), w16(550));
    chk("basic_x", 32'(syn_x), 0);
    tick();
    chk("basic_idle", 32'(busy), 0);

    // disabled partial and saturation
    wr(2, 1'b0, 300);
    one_sample("disable2", 250);
    load4(16000, 16000, 16000, 16000);
    one_sample("sat_pos", 32767);
    load4(-16000, -16000, -16000, -16000);
    one_sample("sat_neg", -32768);

    // backpressure
    load4(100, 200, 300, -50);
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("bp");
    chk("bp_first", w16(int'(out_data)), w16(550));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", w16(int'(out_data)), w16(550));
      chk("bp_hold_syn_valid", 32'(syn_valid), 0);
      chk("bp_hold_x", 32'(syn_x), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_syn_valid", 32'(syn_valid), 1);
    chk("bp_next_x", 32'(syn_x), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_valid("bp2");
    chk("bp2_data", w16(int'(out_data)), w16(550));
    tick();
    chk("bp2_idle", 32'(busy), 0);

    // shadow commit and clr-over-write
    start = 1'b1; tick(); start = 1'b0;
    wr(1, 1'b1, 0);
    wait_valid("sh0");
    chk("shadow_s0", w16(int'(out_data)), w16(550));
    tick();
    clr = 1'b1; cfg_wr_en = 1'b1; cfg_idx = 2'd0; cfg_enable = 1'b1; cfg_magnitude = 16'd1000;
    tick();
    clr = 1'b0; cfg_wr_en = 1'b0;
    wait_valid("sh1");
    chk("shadow_s1", w16(int'(out_data)), w16(350));
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_valid("sh2");
    chk("clr_s2", w16(int'(out_data)), w16(0));
    tick();
    chk("clr_idle", 32'(busy), 0);

    // x wrap over 2048 samples, then stop during DRAIN
    wr(0, 1'b1, 100);
    start = 1'b1; tick(); start = 1'b0;
    n = 0; acc_cnt = 0;
    while (!(syn_valid && syn_x == 11'd2047) && n < 20000) begin
      if (out_valid && out_ready) acc_cnt++;
      tick(); n++;
    end
    chk("wrap_reach_2047", 32'(syn_x), 2047);
    chk("wrap_accept_count", 32'(acc_cnt), 2047);
    wait_valid("wrap_last");
    chk("wrap_last_data", w16(int'(out_data)), w16(100));
    tick();
    chk("wrap_syn_valid", 32'(syn_valid), 1);
    chk("wrap_x_zero", 32'(syn_x), 0);
    tick(); tick(); tick(); tick();
    chk("stop_in_drain", 32'(syn_valid), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    chk("stop_emit_valid", 32'(out_valid), 1);
    chk("stop_emit_data", w16(int'(out_data)), w16(100));
    tick();
    chk("stop_busy_drop", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (syn_valid) seen = 1'b1;
      tick();
    end
    chk("stop_no_more_issue", 32'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
